if_id_skid_reg: RTL and testbench



---
 rtl/riscv_pipe_pkg.sv | 16 +
 rtl/pipe_slot.sv | 32 +++
 rtl/if_id_skid_reg.sv | 115 +++++++++++
 tb/tb_if_id_skid_reg.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline constants and types for the IF/ID stage registers.
package riscv_pipe_pkg;

  localparam int unsigned PC_W_DEF      = 32;
  localparam int unsigned INSTR_W_DEF   = 32;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;

  // Number of valid entries held by the skid register.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_t;

endpackage

// File: rtl/pipe_slot.sv
// Load-enabled {pc,instr} holding register with async reset; clear replaces instr with a bubble.
module pipe_slot #(
  parameter int unsigned         PC_W      = 32,
  parameter int unsigned         INSTR_W   = 32,
  parameter logic [PC_W-1:0]     RST_PC    = '0,
  parameter logic [INSTR_W-1:0]  RST_INSTR = '0,
  parameter logic [INSTR_W-1:0]  CLR_INSTR = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               clear,
  input  logic [PC_W-1:0]    d_pc,
  input  logic [INSTR_W-1:0] d_instr,
  output logic [PC_W-1:0]    q_pc,
  output logic [INSTR_W-1:0] q_instr
);

  // Clear leaves the PC untouched so Decode still sees the last PC.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_pc    <= RST_PC;
      q_instr <= RST_INSTR;
    end else if (load) begin
      q_pc    <= d_pc;
      q_instr <= d_instr;
    end else if (clear) begin
      q_instr <= CLR_INSTR;
    end
  end

endmodule

// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register with a 2-entry skid buffer and registered back-pressure.
// Define IF_ID_SKID_STATS_EN to add stall_cycles/flush_count counter outputs.
module if_id_skid_reg
  import riscv_pipe_pkg::*;
#(
  parameter int unsigned        PC_W      = PC_W_DEF,
  parameter int unsigned        INSTR_W   = INSTR_W_DEF,
  parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEF,
  parameter logic [PC_W-1:0]    RESET_PC  = RESET_PC_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr
`ifdef IF_ID_SKID_STATS_EN
  ,
  output logic [31:0]        stall_cycles,
  output logic [31:0]        flush_count
`endif
);

  skid_state_t        state;
  logic               acc, fire;
  logic               main_load, main_clr, main_from_skid, skid_load;
  logic [PC_W-1:0]    skid_pc, main_d_pc;
  logic [INSTR_W-1:0] skid_instr, main_d_instr;

  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);
  assign acc       = in_valid & in_ready;
  assign fire      = out_valid & out_ready;

  always_comb begin
    main_load      = 1'b0;
    main_clr       = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    if (flush) begin
      main_clr = 1'b1;
    end else begin
      unique case (state)
        EMPTY: main_load = acc;
        ONE: begin
          if (acc && fire)  main_load = 1'b1;
          else if (acc)     skid_load = 1'b1;
          else if (fire)    main_clr  = 1'b1;
        end
        TWO: begin
          main_load      = fire;
          main_from_skid = fire;
        end
        default: ;
      endcase
    end
  end

  assign main_d_pc    = main_from_skid ? skid_pc    : in_pc;
  assign main_d_instr = main_from_skid ? skid_instr : in_instr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= EMPTY;
    end else if (flush) begin
      state <= EMPTY;
    end else begin
      unique case (state)
        EMPTY: if (acc) state <= ONE;
        ONE: begin
          if (acc && !fire)      state <= TWO;
          else if (!acc && fire) state <= EMPTY;
        end
        TWO:   if (fire) state <= ONE;
        default: state <= EMPTY;
      endcase
    end
  end

  pipe_slot #(
    .PC_W(PC_W), .INSTR_W(INSTR_W),
    .RST_PC(RESET_PC), .RST_INSTR(NOP_INSTR), .CLR_INSTR(NOP_INSTR)
  ) u_main (
    .clk(clk), .reset(reset), .load(main_load), .clear(main_clr),
    .d_pc(main_d_pc), .d_instr(main_d_instr),
    .q_pc(out_pc), .q_instr(out_instr)
  );

  pipe_slot #(
    .PC_W(PC_W), .INSTR_W(INSTR_W),
    .RST_PC(RESET_PC), .RST_INSTR(NOP_INSTR), .CLR_INSTR(NOP_INSTR)
  ) u_skid (
    .clk(clk), .reset(reset), .load(skid_load), .clear(1'b0),
    .d_pc(in_pc), .d_instr(in_instr),
    .q_pc(skid_pc), .q_instr(skid_instr)
  );

`ifdef IF_ID_SKID_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (in_valid && !in_ready) stall_cycles <= stall_cycles + 32'd1;
      if (flush)                 flush_count  <= flush_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Bench for if_id_skid_reg: directed scenarios plus random traffic against a queue model.
module tb_if_id_skid_reg;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic        in_ready, out_valid;
  logic [31:0] in_pc, in_instr, out_pc, out_instr;
`ifdef IF_ID_SKID_STATS_EN
  logic [31:0] stall_cycles, flush_count;
`endif

  always #5 clk = ~clk;

  if_id_skid_reg #(
    .PC_W(32), .INSTR_W(32), .NOP_INSTR(32'h0000_0013), .RESET_PC(32'h0)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr)
`ifdef IF_ID_SKID_STATS_EN
    , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
  );

  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
  ent_t        q[$];
  logic [31:0] m_last_pc;
  int unsigned m_stall, m_flush;
  int          checks = 0, failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_last_pc = 32'h0;
    m_stall   = 0;
    m_flush   = 0;
  endtask

  task automatic check_outputs();
    check("out_valid", 32'(out_valid), 32'(q.size() > 0));
    check("in_ready",  32'(in_ready),  32'(q.size() < 2));
    check("out_pc",    out_pc, m_last_pc);
    check("out_instr", out_instr, (q.size() > 0) ? q[0].instr : NOP);
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then compare.
  task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] ir,
                      input logic rdy, input logic fl);
    bit acc, fire;
    in_valid  = v;
    in_pc     = pc;
    in_instr  = ir;
    out_ready = rdy;
    flush     = fl;
    acc  = v && (q.size() < 2);
    fire = (q.size() > 0) && rdy;
    if (v && q.size() == 2) m_stall++;
    if (fl) m_flush++;
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (fire) void'(q.pop_front());
      if (acc)  q.push_back('{pc, ir});
    end
    if (q.size() > 0) m_last_pc = q[0].pc;
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    model_reset();
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
    in_valid = 1'b1; in_pc = 32'h100; in_instr = 32'hAAAA_0001;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_instr", out_instr, NOP);
    check("rst_out_pc",    out_pc, 32'h0);
    check("rst_in_ready",  32'(in_ready), 32'd1);
    reset = 1'b0;

    // First accept after reset shows up one cycle later.
    step(1, 32'h100, 32'hAAAA_0001, 0, 0);
    step(0, 32'h0, 32'h0, 1, 0);

    // Streaming with out_ready held high.
    for (int unsigned i = 0; i < 4; i++)
      step(1, 32'(i * 4), 32'hB000_0000 + 32'(i), 1, 0);
    step(0, 32'h0, 32'h0, 1, 0);

    // Back-pressure fills the skid; the third entry must wait.
    step(1, 32'h20, 32'hC000_0020, 0, 0);
    step(1, 32'h24, 32'hC000_0024, 0, 0);
    step(1, 32'h28, 32'hC000_0028, 0, 0);
    check("two_in_ready", 32'(in_ready), 32'd0);
    step(0, 32'h0, 32'h0, 1, 0);
    step(0, 32'h0, 32'h0, 1, 0);
    step(1, 32'h28, 32'hC000_0028, 1, 0);
    step(0, 32'h0, 32'h0, 1, 0);

    // Flush while TWO with a competing input.
    step(1, 32'h40, 32'hD000_0040, 0, 0);
    step(1, 32'h44, 32'hD000_0044, 0, 0);
    step(1, 32'h48, 32'hD000_0048, 1, 1);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_out_instr", out_instr, NOP);
    step(0, 32'h0, 32'h0, 1, 0);

    // Asynchronous reset while TWO: outputs must change before the next edge.
    step(1, 32'h60, 32'hE000_0060, 0, 0);
    step(1, 32'h64, 32'hE000_0064, 0, 0);
    #2 reset = 1'b1;
    #1;
    check("areset_out_valid", 32'(out_valid), 32'd0);
    check("areset_in_ready",  32'(in_ready),  32'd1);
    check("areset_out_pc",    out_pc, 32'h0);
    check("areset_out_instr", out_instr, NOP);
    model_reset();
    @(negedge clk);
    reset = 1'b0;

    for (int unsigned i = 0; i < 400; i++)
      step(($urandom_range(0, 9) < 7), {$urandom_range(0, 32'h3FFF), 2'b00}, $urandom(),
           ($urandom_range(0, 9) < 6), ($urandom_range(0, 19) == 0));

`ifdef IF_ID_SKID_STATS_EN
    check("stall_cycles", stall_cycles, m_stall);
    check("flush_count",  flush_count,  m_flush);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
